// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider (DIV/DIVU/REM/REMU).
//
// One restoring shift-subtract step per clock over a 33-bit partial
// remainder. Divide-by-zero and signed overflow (MOST_NEG / -1) bypass the
// iteration and finish two edges after acceptance. A normal operation
// finishes 34 edges after acceptance.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-low
//   start_i      request a division (accepted in IDLE or DONE)
//   signed_i     1 = two's-complement operands, 0 = unsigned
//   kill_i       flush: return to IDLE, no done_o, results untouched
//   dividend_i   numerator, captured on acceptance
//   divisor_i    denominator, captured on acceptance
//   busy_o       high in PREP and CALC
//   done_o       one-cycle pulse while in DONE
//   quotient_o   registered quotient, held until the next DONE entry
//   remainder_o  registered remainder, held until the next DONE entry
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              kill_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int                CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_signed;
  logic [DATA_W-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   r_b;         // divisor magnitude
  logic [DATA_W:0]     r_rem;       // partial remainder
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_quotient;
  logic [DATA_W-1:0]   r_remainder;

  logic                w_accept;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                w_div0;
  logic                w_ovf;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_diff;
  logic                w_qbit;
  logic [DATA_W:0]     w_rem_nx;
  logic [DATA_W-1:0]   w_quo_nx;

  // Two's-complement negate when en is set (also serves as absolute value).
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              en);
    return en ? -v : v;
  endfunction

  assign w_accept = start_i && !kill_i && (r_state == S_IDLE || r_state == S_DONE);

  // Sign flags come from the captured operands, which stay frozen until the
  // next acceptance, so they are still valid when the result is written.
  assign w_a_neg = r_signed & r_dividend[DATA_W-1];
  assign w_b_neg = r_signed & r_divisor[DATA_W-1];
  assign w_div0  = (r_divisor == '0);
  assign w_ovf   = r_signed && (r_dividend == MOST_NEG) && (r_divisor == '1);

  // Restoring step: the borrow out of the 33-bit subtract decides the
  // quotient bit; on borrow the shifted remainder is kept unchanged.
  assign w_rem_sh = {r_rem[DATA_W-1:0], r_quo[DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_qbit   = ~w_diff[DATA_W];
  assign w_rem_nx = w_qbit ? w_diff : w_rem_sh;
  assign w_quo_nx = {r_quo[DATA_W-2:0], w_qbit};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_PREP;
      S_PREP:  w_state_nx = (w_div0 || w_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == LAST_STEP) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = w_accept ? S_PREP : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (kill_i) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_signed    <= 1'b0;
      r_quo       <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (!kill_i) begin
      if (w_accept) begin
        r_dividend <= dividend_i;
        r_divisor  <= divisor_i;
        r_signed   <= signed_i;
      end
      case (r_state)
        S_PREP: begin
          r_quo <= neg_if(r_dividend, w_a_neg);
          r_b   <= neg_if(r_divisor, w_b_neg);
          r_rem <= '0;
          r_cnt <= '0;
          if (w_div0) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
          end else if (w_ovf) begin
            r_quotient  <= MOST_NEG;
            r_remainder <= '0;
          end
        end
        S_CALC: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 1'b1;
          // Last step: write the sign-corrected result straight from the step logic.
          if (r_cnt == LAST_STEP) begin
            r_quotient  <= neg_if(w_quo_nx, w_a_neg ^ w_b_neg);
            r_remainder <= neg_if(w_rem_nx[DATA_W-1:0], w_a_neg);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state == S_PREP) || (r_state == S_CALC);
  assign done_o      = (r_state == S_DONE);
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset:
- clk_i  input  1  rising-edge clock
- rst_i  input  1  asynchronous reset, active-low
REQ-002 SHALL have these ports:
- start_i  input  1  request a division; sampled at the rising edge
- signed_i  input  1  1 = two's-complement operands (DIV/REM); 0 = unsigned (DIVU/REMU)
- kill_i  input  1  pipeline flush; aborts any operation in progress
- dividend_i  input  32  numerator; captured when start is accepted
- divisor_i  input  32  denominator; captured when start is accepted
- busy_o  output  1  high while an operation is in progress
- done_o  output  1  one-cycle pulse when results are valid
- quotient_o  output  32  registered quotient
- remainder_o  output  32  registered remainder

Function
REQ-003 SHALL implement states IDLE, PREP, CALC and DONE.
REQ-004 SHALL accept start_i only in IDLE or DONE; acceptance captures operands and signed_i, and the next state is PREP.
REQ-005 SHALL ignore start_i in PREP and CALC; the captured operands SHALL NOT change.
REQ-006 In PREP, SHALL form the absolute values (signed mode) and detect special cases; next state is DONE for a special case, otherwise CALC with the iteration counter cleared.
REQ-007 In CALC, SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, using a 33-bit partial remainder; after the 32nd step the next state is DONE.
REQ-008 On entry to DONE, SHALL load quotient_o and remainder_o with the final values.
- signed mode: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
REQ-009 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, in both modes.
REQ-010 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-011 done_o SHALL be high exactly while in DONE (one cycle); DONE SHALL go to IDLE unless start is accepted.
REQ-012 busy_o SHALL be high in PREP and CALC and low in IDLE and DONE.
REQ-013 Latency from the accepting edge to the edge entering DONE SHALL be 34 edges for a normal operation and 2 edges for a special case.
REQ-014 quotient_o and remainder_o SHALL hold their value until the next entry into DONE.
REQ-015 kill_i high at an edge SHALL force IDLE from any state, with no done_o and outputs unchanged.
REQ-016 kill_i SHALL take priority over a simultaneous start_i.

Reset
REQ-017 rst_i low SHALL immediately, independent of clk_i, force IDLE and clear to 0: busy_o, done_o, quotient_o, remainder_o, the iteration counter and all internal operand registers.
REQ-018 Reset asserted mid-operation SHALL abandon the operation; no done_o SHALL follow reset release.
REQ-019 After rst_i deasserts, the first start SHALL be accepted at the first rising edge with start_i high.

Verification
REQ-020 Signed 100 / -7 (0x00000064 / 0xFFFFFFF9) -> done_o 34 edges after start; quotient 0xFFFFFFF2, remainder 0x00000002; busy_o high for 33 cycles.
REQ-021 Unsigned 0xFFFFFFFF / 0x00000002 -> quotient 0x7FFFFFFF, remainder 0x00000001; same 0xFFFFFFFF / 2 signed -> quotient 0, remainder 0xFFFFFFFF.
REQ-022 Signed -5 / 0 -> done_o 2 edges after start; quotient 0xFFFFFFFF, remainder 0xFFFFFFFB. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, 2-edge latency.
REQ-023 Second start with new operands during CALC iteration 10 -> ignored; the first operation's results appear at the original time. Back-to-back start in DONE -> accepted, next done_o 34 edges later.
REQ-024 kill_i pulsed at CALC iteration 10 -> IDLE next edge, no done_o, previous results retained.
REQ-025 rst_i low mid-CALC -> all outputs 0 asynchronously; no done_o after release.
